// File: rtl/mems_dac_spi.sv
// mems_dac_spi: serialises one WORD_BITS frame to the MEMS DAC per start request.
// sclk idles high and falls first; the DAC samples on falling edges, so mosi
// only moves on rising edges. All outputs come straight from flops.
//
// state | meaning
// IDLE  | waiting for start; sclk=1, sync_n=1, mosi=0, busy=0
// SHIFT | sync_n low, sclk toggles every CLK_DIV cycles, data MSB first
// GAP   | sync_n back high for SYNC_GAP cycles before busy drops
module mems_dac_spi #(
  parameter int CLK_DIV   = 4,
  parameter int WORD_BITS = 24,
  parameter int SYNC_GAP  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic                 sclk,
  output logic                 sync_n,
  output logic                 mosi
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(WORD_BITS + 1);
  localparam int GAP_W = $clog2(SYNC_GAP + 1);

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(WORD_BITS);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SYNC_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic                 sclk_q, sclk_d;
  logic                 sync_n_q, sync_n_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 tick;
  logic                 last_rise;
  logic                 gap_end;

  // Divider terminal count marks an sclk half-period boundary. bit_q counts
  // falling edges still owed; once it is zero the next rise closes the frame.
  assign tick      = (div_q == '0);
  assign last_rise = tick && !sclk_q && (bit_q == '0);
  assign gap_end   = (gap_q == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)     state_d = S_SHIFT;
      S_SHIFT: if (last_rise) state_d = S_GAP;
      S_GAP:   if (gap_end)   state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and the datapath counters.
  always_comb begin
    div_d    = div_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    sync_n_d = sync_n_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          shreg_d  = data_in;
          div_d    = DIV_LOAD;
          bit_d    = BIT_LOAD;
          sclk_d   = 1'b1;
          sync_n_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        if (tick) begin
          div_d = DIV_LOAD;
          if (sclk_q) begin
            sclk_d = 1'b0;
            bit_d  = bit_q - BIT_W'(1);
          end else if (bit_q == '0) begin
            // Final rise: release sync_n and blank mosi together.
            sclk_d   = 1'b1;
            sync_n_d = 1'b1;
            shreg_d  = '0;
            gap_d    = GAP_LOAD;
          end else begin
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[WORD_BITS-2:0], 1'b0};
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_GAP: begin
        busy_d = 1'b1;
        if (gap_end) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        busy_d   = 1'b0;
        sclk_d   = 1'b1;
        sync_n_d = 1'b1;
        shreg_d  = '0;
      end
    endcase
  end

  // Output and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      shreg_q  <= '0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      shreg_q  <= shreg_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign sclk   = sclk_q;
  assign sync_n = sync_n_q;
  assign mosi   = shreg_q[WORD_BITS-1];

endmodule

// File: tb/tb_mems_dac_spi.sv
`timescale 1ns/1ps
module tb_mems_dac_spi;

  localparam int W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start = 1'b0, start1 = 1'b0;
  logic [W-1:0] data_in = '0, data_in1 = '0;
  logic         busy, done, sclk, sync_n, mosi;
  logic         busy1, done1, sclk1, sync_n1, mosi1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] word;
    int           blen;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  typedef struct {
    int           blen;
    int           nfall;
    int           run;
    logic [W-1:0] word;
    logic         bad_t;
    logic         bad_idle;
    logic         p_sclk;
    logic         p_sync;
    logic         p_mosi;
  } mon_t;
  mon_t m0, m1;

  logic [W-1:0] rom [0:15];

  mems_dac_spi #(.CLK_DIV(2), .WORD_BITS(W), .SYNC_GAP(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .sclk(sclk), .sync_n(sync_n), .mosi(mosi));

  mems_dac_spi #(.CLK_DIV(1), .WORD_BITS(W), .SYNC_GAP(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data_in1),
    .busy(busy1), .done(done1), .sclk(sclk1), .sync_n(sync_n1), .mosi(mosi1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic mon_t mon_clear();
    mon_t m;
    m = '{default: 0};
    m.p_sclk = 1'b1;
    m.p_sync = 1'b1;
    return m;
  endfunction

  // One sample of a DUT's outputs; fin goes high in a done cycle.
  task automatic mon_step(inout mon_t m, input logic bsy, input logic dn, input logic sck,
                          input logic syn, input logic mo, input int div, output logic fin);
    fin = 1'b0;
    if (bsy && m.blen == 0) begin
      m.word = '0; m.nfall = 0; m.bad_t = 1'b0; m.bad_idle = 1'b0;
    end
    if (!syn) begin
      if (m.p_sync) m.run = 1;
      else if (sck != m.p_sclk) begin
        if (m.run != div) m.bad_t = 1'b1;
        m.run = 1;
      end else m.run++;
      if (!m.p_sync && m.p_sclk && !sck) begin
        m.word = {m.word[W-2:0], mo};
        m.nfall++;
      end
      if (!m.p_sync && (mo != m.p_mosi) && !(sck && !m.p_sclk)) m.bad_t = 1'b1;
    end else begin
      if (!m.p_sync && m.run != div) m.bad_t = 1'b1;
      if (mo) m.bad_idle = 1'b1;
      if (!sck) m.bad_t = 1'b1;
    end
    if (bsy) m.blen++;
    else if (dn) fin = 1'b1;
    else m.blen = 0;
    m.p_sclk = sck; m.p_sync = syn; m.p_mosi = mo;
  endtask

  // Monitor for the CLK_DIV=2 instance.
  always @(negedge clk) begin
    logic f;
    exp_t e;
    if (rst) m0 = mon_clear();
    else begin
      mon_step(m0, busy, done, sclk, sync_n, mosi, 2, f);
      if (f) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut0 unexpected done: got done=1, expected no frame pending");
        end else begin
          e = q0.pop_front();
          chk("dut0 word", m0.word, e.word);
          chk("dut0 falling edges", m0.nfall, W);
          chk("dut0 busy length", m0.blen, e.blen);
          chk("dut0 sclk/mosi timing", {m0.bad_t, m0.bad_idle}, 0);
        end
        m0.blen = 0;
      end
    end
  end

  // Monitor for the CLK_DIV=1 instance.
  always @(negedge clk) begin
    logic f;
    exp_t e;
    if (rst) m1 = mon_clear();
    else begin
      mon_step(m1, busy1, done1, sclk1, sync_n1, mosi1, 1, f);
      if (f) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1 unexpected done: got done=1, expected no frame pending");
        end else begin
          e = q1.pop_front();
          chk("dut1 word", m1.word, e.word);
          chk("dut1 falling edges", m1.nfall, W);
          chk("dut1 busy length", m1.blen, e.blen);
          chk("dut1 sclk/mosi timing", {m1.bad_t, m1.bad_idle}, 0);
        end
        m1.blen = 0;
      end
    end
  end

  // Leaves the caller at the negedge of the first cycle after acceptance.
  task automatic pulse_start(input bit which, input logic [W-1:0] w);
    @(negedge clk);
    if (which) begin start1 = 1'b1; data_in1 = w; end
    else begin start = 1'b1; data_in = w; end
    @(negedge clk);
    start = 1'b0; start1 = 1'b0;
  endtask

  // Leaves the caller at the negedge of the done cycle.
  task automatic wait_done(input bit which, input int budget);
    int n = 0;
    while ((which ? done1 : done) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if ((which ? done1 : done) !== 1'b1) begin
      checks++; errors++;
      $display("FAIL done timeout dut%0d: got no done in %0d cycles, expected one", which, budget);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no end of run, expected $finish");
    $fatal(1);
  end

  initial begin
    int nf;
    logic ps;
    int addr_seq [3] = '{0, 1, 8};

    for (int i = 0; i < 16; i++) rom[i] = 24'h0F0000 + W'(i * 24'h111);
    rom[0] = 24'h0A0000;
    rom[1] = 24'h0A1111;
    rom[8] = 24'h0B8888;

    // Reset with start held high: reset wins.
    start = 1'b1;
    data_in = 24'hFFFFFF;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sclk", sclk, 1);
    chk("reset sync_n", sync_n, 1);
    chk("reset mosi", mosi, 0);
    chk("reset dut1 sclk", sclk1, 1);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post-reset busy", busy, 0);

    // Single frame, first-cycle outputs.
    q0.push_back('{24'h280001, 98});
    pulse_start(0, 24'h280001);
    chk("first cycle busy", busy, 1);
    chk("first cycle sync_n", sync_n, 0);
    chk("first cycle sclk", sclk, 1);
    chk("first cycle mosi", mosi, 0);
    wait_done(0, 200);

    // start pulses during a frame are ignored.
    q0.push_back('{24'h3FFFFF, 98});
    pulse_start(0, 24'h3FFFFF);
    repeat (4) @(negedge clk);
    start = 1'b1; data_in = 24'h123456;
    @(negedge clk); start = 1'b0;
    repeat (34) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (49) @(negedge clk);
    start = 1'b1; data_in = 24'h000000;
    @(negedge clk); start = 1'b0;
    wait_done(0, 200);
    repeat (2) @(negedge clk);
    chk("no retrigger busy", busy, 0);

    // Back-to-back: start in the done cycle.
    q0.push_back('{24'h000000, 98});
    pulse_start(0, 24'h000000);
    wait_done(0, 200);
    chk("done cycle busy", busy, 0);
    start = 1'b1; data_in = 24'h18A5A5;
    q0.push_back('{24'h18A5A5, 98});
    @(negedge clk); start = 1'b0;
    chk("b2b busy", busy, 1);
    chk("b2b mosi msb", mosi, 0);
    wait_done(0, 200);

    // Abort at the 10th falling edge.
    pulse_start(0, 24'h555555);
    nf = 0; ps = sclk;
    for (int i = 0; i < 300 && nf < 10; i++) begin
      @(negedge clk);
      if (ps && !sclk) nf++;
      ps = sclk;
    end
    chk("abort reached 10 falls", nf, 10);
    rst = 1'b1;
    @(negedge clk);
    chk("abort sync_n", sync_n, 1);
    chk("abort sclk", sclk, 1);
    chk("abort busy", busy, 0);
    chk("abort mosi", mosi, 0);
    chk("abort done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort stays idle", busy, 0);
    q0.push_back('{24'hC3A5F0, 98});
    pulse_start(0, 24'hC3A5F0);
    wait_done(0, 200);

    // CLK_DIV=1 instance.
    q1.push_back('{24'hAAAAAA, 50});
    pulse_start(1, 24'hAAAAAA);
    chk("dut1 first cycle mosi", mosi1, 1);
    @(negedge clk);
    chk("dut1 first fall", sclk1, 0);
    wait_done(1, 100);

    // Sequencer model: soft reset, then ROM words at 0, 1, 8, start only when idle.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 200 && busy; n++) @(negedge clk);
      chk("seq idle before start", busy, 0);
      q0.push_back('{rom[addr_seq[k]], 98});
      pulse_start(0, rom[addr_seq[k]]);
      chk("seq busy after start", busy, 1);
      wait_done(0, 200);
    end

    repeat (20) @(negedge clk);
    chk("dut0 frames outstanding", q0.size(), 0);
    chk("dut1 frames outstanding", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
